// File: rtl/cache_ctrl_pkg.sv
// Shared types and defaults for the cache tag/data RAM controllers.
// Geometry macros fall back to the standard cache configuration when not set by the build.
`ifndef BLOCK_CNT
`define BLOCK_CNT 6
`endif
`ifndef TAG_CNT
`define TAG_CNT 8
`endif
`ifndef DOSA
`define DOSA 4
`endif

package cache_ctrl_pkg;

    localparam int IDX_W_DEF      = `BLOCK_CNT;
    localparam int TAG_W_DEF      = `TAG_CNT;
    localparam int WAYS_DEF       = `DOSA;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        LK_ISSUE,
        LK_WAIT,
        RF_ISSUE,
        RF_WAIT
    } tag_ctrl_state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_DEF-1:0] tag;
    } tag_entry_t;

    // Way-number width, never narrower than one bit.
    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/tag_match.sv
// Combinational DOSA-way tag compare: per-way match, hit, lowest matching way, multi-hit.
module tag_match
    import cache_ctrl_pkg::*;
#(
    parameter int WAYS  = WAYS_DEF,
    parameter int TAG_W = TAG_W_DEF,
    parameter int WAY_W = way_w(WAYS)
) (
    input  logic [WAYS*(TAG_W+1)-1:0] entries,
    input  logic [TAG_W-1:0]          tag,
    output logic [WAYS-1:0]           match,
    output logic                      hit,
    output logic [WAY_W-1:0]          way,
    output logic                      multi
);

    for (genvar k = 0; k < WAYS; k++) begin : g_cmp
        assign match[k] = entries[k*(TAG_W+1)+TAG_W]
                          && (entries[k*(TAG_W+1) +: TAG_W] == tag);
    end

    assign hit = |match;

    // Clearing the lowest set bit leaves something behind only when two or more ways match.
    assign multi = |(match & (match - WAYS'(1)));

    always_comb begin
        way = '0;
        for (int unsigned k = WAYS; k > 0; k--) begin
            if (match[k-1]) way = WAY_W'(k - 1);
        end
    end

endmodule

// File: rtl/tag_ctrl.sv
// Tag RAM sequencer: arbitrates PE lookups against memory-side refills, one RAM operation
// at a time, with round-robin victim selection and a starvation guard for lookups.
module tag_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int IDX_W      = IDX_W_DEF,
    parameter int TAG_W      = TAG_W_DEF,
    parameter int WAYS       = WAYS_DEF,
    parameter int WAY_W      = way_w(WAYS),
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      lk_valid,
    output logic                      lk_ready,
    input  logic [IDX_W-1:0]          lk_index,
    input  logic [TAG_W-1:0]          lk_tag,
    output logic                      lk_rsp_valid,
    output logic                      lk_hit,
    output logic [WAY_W-1:0]          lk_way,

    input  logic                      rf_valid,
    output logic                      rf_ready,
    input  logic [IDX_W-1:0]          rf_index,
    input  logic [TAG_W-1:0]          rf_tag,
    output logic                      rf_rsp_valid,
    output logic [WAY_W-1:0]          rf_way,
    output logic                      rf_evict_valid,
    output logic [TAG_W-1:0]          rf_evict_tag,

    output logic                      err_multihit,

    output logic                      ram_pe_en,
    output logic [IDX_W-1:0]          ram_pe_index,
    output logic                      ram_mem_en,
    output logic [WAY_W-1:0]          ram_set,
    output logic [IDX_W-1:0]          ram_mem_index,
    output logic [TAG_W-1:0]          ram_tag_upd,
    input  logic [WAYS*(TAG_W+1)-1:0] ram_tag_x,
    input  logic [TAG_W:0]            ram_tag_repl
);

    localparam int SC_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    tag_ctrl_state_t  state;
    logic [IDX_W-1:0] idx_q;
    logic [TAG_W-1:0] tag_q;
    logic [WAY_W-1:0] vptr;
    logic [SC_W-1:0]  starve_cnt;
    logic             starved;

    logic [WAYS-1:0]  match_vec;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             multi;

    tag_match #(
        .WAYS  (WAYS),
        .TAG_W (TAG_W),
        .WAY_W (WAY_W)
    ) u_match (
        .entries (ram_tag_x),
        .tag     (tag_q),
        .match   (match_vec),
        .hit     (hit),
        .way     (hit_way),
        .multi   (multi)
    );

    always_comb assert (hit == (|match_vec));

    // Once refills have been granted STARVE_MAX times back-to-back over a waiting lookup,
    // the lookup takes the next slot.
    assign starved  = (starve_cnt == SC_W'(STARVE_MAX)) && lk_valid;
    assign rf_ready = (state == IDLE) && rf_valid && !starved;
    assign lk_ready = (state == IDLE) && lk_valid && !rf_ready;

    assign ram_pe_en     = (state == LK_ISSUE);
    assign ram_mem_en    = (state == RF_ISSUE);
    assign ram_pe_index  = ram_pe_en  ? idx_q : '0;
    assign ram_set       = ram_mem_en ? vptr  : '0;
    assign ram_mem_index = ram_mem_en ? idx_q : '0;
    assign ram_tag_upd   = ram_mem_en ? tag_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx_q          <= '0;
            tag_q          <= '0;
            vptr           <= '0;
            starve_cnt     <= '0;
            lk_rsp_valid   <= 1'b0;
            lk_hit         <= 1'b0;
            lk_way         <= '0;
            rf_rsp_valid   <= 1'b0;
            rf_way         <= '0;
            rf_evict_valid <= 1'b0;
            rf_evict_tag   <= '0;
            err_multihit   <= 1'b0;
        end else begin
            lk_rsp_valid <= 1'b0;
            rf_rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rf_ready) begin
                        state <= RF_ISSUE;
                        idx_q <= rf_index;
                        tag_q <= rf_tag;
                        if (!lk_valid)
                            starve_cnt <= '0;
                        else if (starve_cnt != SC_W'(STARVE_MAX))
                            starve_cnt <= starve_cnt + SC_W'(1);
                    end else if (lk_ready) begin
                        state      <= LK_ISSUE;
                        idx_q      <= lk_index;
                        tag_q      <= lk_tag;
                        starve_cnt <= '0;
                    end else if (!lk_valid) begin
                        starve_cnt <= '0;
                    end
                end
                LK_ISSUE: state <= LK_WAIT;
                LK_WAIT: begin
                    lk_rsp_valid <= 1'b1;
                    lk_hit       <= hit;
                    lk_way       <= hit_way;
                    err_multihit <= err_multihit | multi;
                    state        <= IDLE;
                end
                RF_ISSUE: state <= RF_WAIT;
                RF_WAIT: begin
                    rf_rsp_valid   <= 1'b1;
                    rf_way         <= vptr;
                    rf_evict_valid <= ram_tag_repl[TAG_W];
                    rf_evict_tag   <= ram_tag_repl[TAG_W-1:0];
                    vptr           <= (vptr == WAY_W'(WAYS - 1)) ? '0 : vptr + WAY_W'(1);
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
